// File: rtl/ysyx_23060042_ifetch.sv
// Multi-cycle instruction fetch: owns the PC, issues one memory read at a time and
// holds the fetched word for decode. Define YSYX_23060042_IFETCH_MISALIGN_EN to trap
// misaligned PCs locally instead of sending them to memory.
module ysyx_23060042_ifetch #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(32'h8000_0000)
) (
    input  logic              clk,
    input  logic              rst,
    output logic              req_valid,
    input  logic              req_ready,
    output logic [ADDR_W-1:0] req_addr,
    input  logic              rsp_valid,
    input  logic [31:0]       rsp_data,
    input  logic              rsp_err,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_pc,
    output logic [31:0]       out_inst,
    output logic              out_err,
    output logic              out_misalign,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic [ADDR_W-1:0] next_pc_q, next_pc_d;
    logic              drop_q, drop_d;
    logic [ADDR_W-1:0] out_pc_q, out_pc_d;
    logic [31:0]       out_inst_q, out_inst_d;
    logic              out_err_q, out_err_d;
    logic [ADDR_W-1:0] resume_pc;
    logic              skip_req;

    function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] pc);
        return pc + ADDR_W'(4);
    endfunction

`ifdef YSYX_23060042_IFETCH_MISALIGN_EN
    logic out_mis_q, out_mis_d;
    // A misaligned address never reaches memory; it becomes a faulting entry instead.
    assign skip_req     = (req_addr_q[1:0] != 2'b00);
    assign out_misalign = out_mis_q;
`else
    assign skip_req     = 1'b0;
    assign out_misalign = 1'b0;
`endif

    assign resume_pc = redirect_valid ? redirect_pc : next_pc_q;

    assign req_valid = (state_q == REQ) && !skip_req;
    assign req_addr  = req_addr_q;
    assign out_valid = (state_q == HOLD) && !redirect_valid;
    assign out_pc    = out_pc_q;
    assign out_inst  = out_inst_q;
    assign out_err   = out_err_q;

    always_comb begin
        state_d    = state_q;
        req_addr_d = req_addr_q;
        next_pc_d  = next_pc_q;
        drop_d     = drop_q;
        out_pc_d   = out_pc_q;
        out_inst_d = out_inst_q;
        out_err_d  = out_err_q;
`ifdef YSYX_23060042_IFETCH_MISALIGN_EN
        out_mis_d  = out_mis_q;
`endif
        unique case (state_q)
            IDLE: begin
                state_d    = REQ;
                req_addr_d = resume_pc;
            end
            REQ: begin
                if (skip_req) begin
                    if (redirect_valid) begin
                        req_addr_d = redirect_pc;
                        next_pc_d  = redirect_pc;
                    end else begin
                        state_d    = HOLD;
                        out_pc_d   = req_addr_q;
                        out_inst_d = '0;
                        out_err_d  = 1'b1;
`ifdef YSYX_23060042_IFETCH_MISALIGN_EN
                        out_mis_d  = 1'b1;
`endif
                    end
                end else begin
                    // req_addr stays put until accepted; a redirect only retargets next_pc.
                    if (req_ready) begin
                        state_d = WAIT;
                        if (!drop_q && !redirect_valid) begin
                            next_pc_d = pc_inc(req_addr_q);
                        end
                    end
                    if (redirect_valid) begin
                        next_pc_d = redirect_pc;
                        drop_d    = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (rsp_valid) begin
                    if (drop_q || redirect_valid) begin
                        state_d    = REQ;
                        drop_d     = 1'b0;
                        req_addr_d = resume_pc;
                        next_pc_d  = resume_pc;
                    end else begin
                        state_d    = HOLD;
                        out_pc_d   = req_addr_q;
                        out_inst_d = rsp_data;
                        out_err_d  = rsp_err;
`ifdef YSYX_23060042_IFETCH_MISALIGN_EN
                        out_mis_d  = 1'b0;
`endif
                    end
                end else if (redirect_valid) begin
                    next_pc_d = redirect_pc;
                    drop_d    = 1'b1;
                end
            end
            HOLD: begin
                // out_valid is already low under a redirect, so no handshake can occur.
                if (redirect_valid) begin
                    state_d    = REQ;
                    req_addr_d = redirect_pc;
                    next_pc_d  = redirect_pc;
                end else if (out_ready) begin
                    state_d    = REQ;
                    req_addr_d = next_pc_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            req_addr_q <= '0;
            next_pc_q  <= RESET_PC;
            drop_q     <= 1'b0;
            out_pc_q   <= '0;
            out_inst_q <= '0;
            out_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_addr_q <= req_addr_d;
            next_pc_q  <= next_pc_d;
            drop_q     <= drop_d;
            out_pc_q   <= out_pc_d;
            out_inst_q <= out_inst_d;
            out_err_q  <= out_err_d;
        end
    end

`ifdef YSYX_23060042_IFETCH_MISALIGN_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            out_mis_q <= 1'b0;
        end else begin
            out_mis_q <= out_mis_d;
        end
    end
`endif

endmodule

// File: tb/tb_ysyx_23060042_ifetch.sv
// Scoreboard bench for ysyx_23060042_ifetch: a latency-programmable memory model
// answers requests; expected request addresses and decode entries are queued up front.
module tb_ysyx_23060042_ifetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_data;
    logic        out_valid, out_ready;
    logic [31:0] out_pc, out_inst;
    logic        out_err, out_misalign;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    always #5 clk = ~clk;

    ysyx_23060042_ifetch #(
        .ADDR_W  (32),
        .RESET_PC(32'h8000_0000)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_addr      (req_addr),
        .rsp_valid     (rsp_valid),
        .rsp_data      (rsp_data),
        .rsp_err       (rsp_err),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_pc        (out_pc),
        .out_inst      (out_inst),
        .out_err       (out_err),
        .out_misalign  (out_misalign),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        err;
        logic        mis;
    } exp_t;

    logic [31:0] exp_req[$];
    exp_t        exp_out[$];
    int          n_vec  = 0;
    int          n_miss = 0;
    int          n_tick = 0;

    // Memory model state: one outstanding read, answered lat cycles after acceptance.
    int          lat = 1;
    logic        pend = 1'b0;
    int          cnt = 0;
    logic [31:0] pend_addr = 32'h0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h8000_0000: return 32'h0000_0413;
            32'h8000_0004: return 32'hdead_beef;
            default:       return {a[15:0], a[31:16]} ^ 32'h0000_0013;
        endcase
    endfunction

    function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] inst,
                                input logic err, input logic mis);
        exp_t e;
        e.pc = pc; e.inst = inst; e.err = err; e.mis = mis;
        return e;
    endfunction

    task automatic chk_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock cycle, entered and left just after a falling edge.
    task automatic tick();
        logic req_hs, out_hs, rsp_now;
        exp_t e;
        rsp_now   = pend && (cnt == 0);
        rsp_valid = rsp_now;
        rsp_data  = rsp_now ? mem_word(pend_addr) : 32'h0;
        rsp_err   = rsp_now && (pend_addr == 32'h8000_0008);
        #1;
        req_hs = req_valid && req_ready;
        out_hs = out_valid && out_ready;
        if (req_hs) begin
            if (exp_req.size() == 0) chk_vec("req_unexpected", 32'(req_hs), 32'h0);
            else                     chk_vec("req_addr", req_addr, exp_req.pop_front());
        end
        if (out_hs) begin
            if (exp_out.size() == 0) begin
                chk_vec("out_unexpected", 32'(out_hs), 32'h0);
            end else begin
                e = exp_out.pop_front();
                chk_vec("out_pc", out_pc, e.pc);
                chk_vec("out_inst", out_inst, e.inst);
                chk_vec("out_err", 32'(out_err), 32'(e.err));
                chk_vec("out_misalign", 32'(out_misalign), 32'(e.mis));
            end
        end
        if (rsp_now)   pend = 1'b0;
        else if (pend) cnt--;
        if (req_hs) begin
            pend      = 1'b1;
            cnt       = lat - 1;
            pend_addr = req_addr;
        end
        @(posedge clk);
        @(negedge clk);
        rsp_valid = 1'b0;
        n_tick++;
        if (n_tick > 20000) begin
            $display("FAIL cycle_budget: got %0d expected below 20000", n_tick);
            $fatal(1);
        end
    endtask

    task automatic run_until_drained(input int max);
        int n = 0;
        while ((exp_req.size() != 0 || exp_out.size() != 0) && n < max) begin
            tick();
            n++;
        end
        chk_vec("drain_left", 32'(exp_req.size() + exp_out.size()), 32'h0);
    endtask

    task automatic wait_hold(input int max);
        int n = 0;
        while (!out_valid && n < max) begin
            tick();
            n++;
        end
        chk_vec("hold_reached", 32'(out_valid), 32'h1);
    endtask

    task automatic chk_reset_outputs();
        chk_vec("rst_req_valid", 32'(req_valid), 32'h0);
        chk_vec("rst_out_valid", 32'(out_valid), 32'h0);
        chk_vec("rst_out_pc", out_pc, 32'h0);
        chk_vec("rst_out_inst", out_inst, 32'h0);
        chk_vec("rst_out_err", 32'(out_err), 32'h0);
        chk_vec("rst_out_misalign", 32'(out_misalign), 32'h0);
    endtask

    initial begin
        int n;
        rst = 1'b1; req_ready = 1'b1; rsp_valid = 1'b0; rsp_data = 32'h0; rsp_err = 1'b0;
        out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        @(negedge clk);
        tick();
        tick();
        chk_reset_outputs();

        // First fetch after reset, then decode stalls for five cycles.
        exp_req.push_back(32'h8000_0000);
        exp_out.push_back(mk(32'h8000_0000, 32'h0000_0413, 1'b0, 1'b0));
        rst = 1'b0;
        n = 0;
        while (!out_valid && n < 10) begin
            tick();
            n++;
        end
        chk_vec("first_out_lat", 32'(n), 32'd3);
        chk_vec("first_out_pc", out_pc, 32'h8000_0000);
        chk_vec("first_out_inst", out_inst, 32'h0000_0413);
        chk_vec("first_out_err", 32'(out_err), 32'h0);
        for (int i = 0; i < 5; i++) begin
            chk_vec("stall_out_valid", 32'(out_valid), 32'h1);
            chk_vec("stall_req_valid", 32'(req_valid), 32'h0);
            chk_vec("stall_out_pc", out_pc, 32'h8000_0000);
            chk_vec("stall_out_inst", out_inst, 32'h0000_0413);
            tick();
        end

        // Redirect while waiting: the 80000004 response must be discarded.
        exp_req.push_back(32'h8000_0004);
        out_ready = 1'b1;
        tick();
        lat = 3;
        tick();
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0100;
        tick();
        redirect_valid = 1'b0;
        lat = 1;
        exp_req.push_back(32'h8000_0100);
        exp_out.push_back(mk(32'h8000_0100, mem_word(32'h8000_0100), 1'b0, 1'b0));
        run_until_drained(20);

        // Redirect in HOLD with decode ready: the held entry is squashed.
        exp_req.push_back(32'h8000_0104);
        wait_hold(10);
        chk_vec("squash_pc", out_pc, 32'h8000_0104);
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0200;
        #1;
        chk_vec("squash_out_valid", 32'(out_valid), 32'h0);
        tick();
        redirect_valid = 1'b0;
        exp_req.push_back(32'h8000_0200);
        exp_out.push_back(mk(32'h8000_0200, mem_word(32'h8000_0200), 1'b0, 1'b0));
        exp_req.push_back(32'h8000_0204);
        exp_out.push_back(mk(32'h8000_0204, mem_word(32'h8000_0204), 1'b0, 1'b0));
        run_until_drained(30);

        // Redirect coinciding with a request handshake; target fetch faults.
        chk_vec("req_state", 32'(req_valid), 32'h1);
        chk_vec("req_addr_now", req_addr, 32'h8000_0208);
        exp_req.push_back(32'h8000_0208);
        exp_req.push_back(32'h8000_0008);
        exp_out.push_back(mk(32'h8000_0008, mem_word(32'h8000_0008), 1'b1, 1'b0));
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0008;
        tick();
        redirect_valid = 1'b0;
        run_until_drained(30);

        // Redirect while memory stalls: address held, then PC wraps past FFFFFFFC.
        req_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        chk_vec("stable_req_valid", 32'(req_valid), 32'h1);
        chk_vec("stable_req_addr", req_addr, 32'h8000_000C);
        tick();
        chk_vec("stable_req_addr2", req_addr, 32'h8000_000C);
        req_ready = 1'b1;
        exp_req.push_back(32'h8000_000C);
        exp_req.push_back(32'hFFFF_FFFC);
        exp_out.push_back(mk(32'hFFFF_FFFC, mem_word(32'hFFFF_FFFC), 1'b0, 1'b0));
        exp_req.push_back(32'h0000_0000);
        exp_out.push_back(mk(32'h0000_0000, mem_word(32'h0000_0000), 1'b0, 1'b0));
        run_until_drained(40);

        // Reset during WAIT; the late response must be ignored.
        exp_req.push_back(32'h0000_0004);
        lat = 4;
        tick();
        lat = 1;
        rst = 1'b1;
        tick();
        tick();
        chk_reset_outputs();
        rst = 1'b0;
        exp_req.push_back(32'h8000_0000);
        exp_out.push_back(mk(32'h8000_0000, 32'h0000_0413, 1'b0, 1'b0));
        run_until_drained(20);

`ifdef YSYX_23060042_IFETCH_MISALIGN_EN
        out_ready = 1'b0;
        exp_req.push_back(32'h8000_0004);
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0102;
        tick();
        redirect_valid = 1'b0;
        wait_hold(10);
        chk_vec("mis_flag", 32'(out_misalign), 32'h1);
        chk_vec("mis_err", 32'(out_err), 32'h1);
        chk_vec("mis_inst", out_inst, 32'h0);
        chk_vec("mis_pc", out_pc, 32'h8000_0102);
        chk_vec("mis_req_valid", 32'(req_valid), 32'h0);
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0300;
        tick();
        redirect_valid = 1'b0;
        out_ready = 1'b1;
        exp_req.push_back(32'h8000_0300);
        exp_out.push_back(mk(32'h8000_0300, mem_word(32'h8000_0300), 1'b0, 1'b0));
        run_until_drained(20);
`else
        exp_req.push_back(32'h8000_0004);
        exp_req.push_back(32'h8000_0102);
        exp_out.push_back(mk(32'h8000_0102, mem_word(32'h8000_0102), 1'b0, 1'b0));
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0102;
        tick();
        redirect_valid = 1'b0;
        run_until_drained(20);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got time %0t expected completion", $time);
        $fatal(1);
    end

endmodule
